// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM definitions for the ALU issue controller.
package alu_pkg;

    localparam logic [3:0] OP_ADD         = 4'b0000;
    localparam logic [3:0] OP_SUB         = 4'b0001;
    localparam logic [3:0] OP_AND         = 4'b0010;
    localparam logic [3:0] OP_OR          = 4'b0011;
    localparam logic [3:0] OP_XOR         = 4'b0100;
    localparam logic [3:0] OP_NOT         = 4'b0101;
    localparam logic [3:0] OP_SHL         = 4'b0110;
    localparam logic [3:0] OP_SHR         = 4'b0111;
    localparam logic [3:0] OP_SAR         = 4'b1000;
    localparam logic [3:0] OP_SLT         = 4'b1001;
    localparam logic [3:0] OP_SLTU        = 4'b1010;
    localparam logic [3:0] OP_PASSB       = 4'b1011;
    localparam logic [3:0] OP_ROL         = 4'b1100;
    localparam logic [3:0] OP_ROR         = 4'b1101;
    localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1110;

    localparam int FLG_Z = 3;
    localparam int FLG_S = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op < OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, load, response and ALU-side signals of the issue controller.
interface alu_issue_ctrl_if #(
    parameter int DW = 8,
    parameter int RW = 2
);
    logic          ld_valid;
    logic [RW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [RW-1:0] cmd_rd;
    logic [RW-1:0] cmd_rs1;
    logic [RW-1:0] cmd_rs2;
    logic          cmd_imm_en;
    logic [DW-1:0] cmd_imm;
    logic          cmd_wb;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_z;
    logic          alu_s;
    logic          alu_c;
    logic          alu_v;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [3:0]    rsp_flags;
    logic          rsp_err;

    // The master side is the instruction source together with the ALU instance.
    modport master (
        output ld_valid, ld_addr, ld_data,
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_wb,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_z, alu_s, alu_c, alu_v,
        input  rsp_valid, rsp_data, rsp_flags, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data,
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm, cmd_wb,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_z, alu_s, alu_c, alu_v,
        output rsp_valid, rsp_data, rsp_flags, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_regfile.sv
// Operand register file: two asynchronous read ports, one synchronous write port.
module alu_regfile #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int RW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [RW-1:0] raddr2,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] words [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_word
            logic [DW-1:0] word_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (we && waddr == RW'(gi)) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata1 = words[raddr1];
    assign rdata2 = words[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation per accepted command, writes back the result and
// returns result plus flags over a response handshake.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int RW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus
);

    state_t        state_reg;
    logic [DW-1:0] alu_a_reg;
    logic [DW-1:0] alu_b_reg;
    logic [3:0]    alu_op_reg;
    logic [RW-1:0] rd_reg;
    logic          wb_reg;
    logic [3:0]    flags_reg;
    logic          rsp_valid_reg;
    logic [DW-1:0] rsp_data_reg;
    logic [3:0]    rsp_flags_reg;
    logic          rsp_err_reg;

    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          we;
    logic [RW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ld_fire;
    logic          accept;
    logic [3:0]    alu_flags;

    assign ld_fire   = (state_reg == IDLE) && bus.ld_valid;
    assign accept    = (state_reg == IDLE) && !bus.ld_valid && bus.cmd_valid;
    assign alu_flags = {bus.alu_z, bus.alu_s, bus.alu_c, bus.alu_v};

    // A direct load and a writeback can never coincide: loads only land in IDLE.
    always_comb begin
        we    = 1'b0;
        waddr = bus.ld_addr;
        wdata = bus.ld_data;
        if (ld_fire) begin
            we = 1'b1;
        end else if (state_reg == EXEC && wb_reg) begin
            we    = 1'b1;
            waddr = rd_reg;
            wdata = bus.alu_result;
        end
    end

    alu_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .RW   (RW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (bus.cmd_rs1),
        .rdata1 (rs1_data),
        .raddr2 (bus.cmd_rs2),
        .rdata2 (rs2_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= 4'b0000;
            rd_reg        <= '0;
            wb_reg        <= 1'b0;
            flags_reg     <= 4'b0000;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_flags_reg <= 4'b0000;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_legal_op(bus.cmd_op)) begin
                            alu_a_reg  <= rs1_data;
                            alu_b_reg  <= bus.cmd_imm_en ? bus.cmd_imm : rs2_data;
                            alu_op_reg <= bus.cmd_op;
                            rd_reg     <= bus.cmd_rd;
                            wb_reg     <= bus.cmd_wb;
                            state_reg  <= EXEC;
                        end else begin
                            // Rejected opcodes leave the ALU inputs and flags alone.
                            rsp_err_reg   <= 1'b1;
                            rsp_data_reg  <= '0;
                            rsp_flags_reg <= flags_reg;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_reg  <= bus.alu_result;
                    rsp_flags_reg <= alu_flags;
                    flags_reg     <= alu_flags;
                    rsp_err_reg   <= 1'b0;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_reg == IDLE) && !bus.ld_valid && !rst;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.alu_op    = alu_op_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_flags = rsp_flags_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and reference model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DW(8), .RW(2)) bus ();

    alu_issue_ctrl #(.DW(8), .NREG(4), .RW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors = 0;
    int errors  = 0;

    // Behavioural 8-bit ALU: returns {result, Z, S, C, V}.
    function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [7:0] res;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            4'd0:  begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            4'd1:  begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = 255 - ua;
            4'd6:  begin r = ua * 2; c = (ua >= 128); end
            4'd7:  begin r = ua / 2; c = (ua % 2 == 1); end
            4'd8:  begin r = ua / 2 + ((ua >= 128) ? 128 : 0); c = (ua % 2 == 1); end
            4'd9:  r = (sa < sb) ? 1 : 0;
            4'd10: r = (ua < ub) ? 1 : 0;
            4'd11: r = ub;
            4'd12: r = (ua * 2) % 256 + ua / 128;
            4'd13: r = ua / 2 + (ua % 2) * 128;
            default: r = 0;
        endcase
        res = r[7:0];
        return {res, (res == 8'd0), res[7], c, v};
    endfunction

    logic [11:0] alu_out;
    assign alu_out        = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_result = alu_out[11:4];
    assign bus.alu_z      = alu_out[3];
    assign bus.alu_s      = alu_out[2];
    assign bus.alu_c      = alu_out[1];
    assign bus.alu_v      = alu_out[0];

    // Reference model state
    logic [7:0] m_rf [4];
    logic [3:0] m_flags;
    logic [3:0] m_last_op;
    logic [7:0] m_last_a, m_last_b;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_flags = 4'h0; m_last_op = 4'h0; m_last_a = 8'h00; m_last_b = 8'h00;
    endtask

    task automatic idle_inputs();
        bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_rd = 0; bus.cmd_rs1 = 0; bus.cmd_rs2 = 0;
        bus.cmd_imm_en = 0; bus.cmd_imm = 0; bus.cmd_wb = 0; bus.rsp_ready = 0;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        bus.ld_valid = 1; bus.ld_addr = a; bus.ld_data = d;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL load_blocks_ready: cmd_ready=%b required 0", bus.cmd_ready);
        end
        @(negedge clk);
        bus.ld_valid = 0;
        m_rf[a] = d;
        $display("load r%0d <= %02h", a, d);
    endtask

    // Issues one command starting just after a negedge and returns once back in IDLE.
    task automatic do_cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm,
                          input logic wb, input int hold, input logic poke, input string name,
                          output logic [7:0] obs_d, output logic [3:0] obs_f);
        logic [7:0] a, b, exp_d;
        logic [3:0] exp_f;
        logic legal;
        int lat;
        a = m_rf[rs1];
        b = imm_en ? imm : m_rf[rs2];
        legal = (op < 4'd14);
        if (legal) {exp_d, exp_f} = alu_ref(op, a, b);
        else begin exp_d = 8'h00; exp_f = m_flags; end

        bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        bus.cmd_imm_en = imm_en; bus.cmd_imm = imm; bus.cmd_wb = wb;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_idle: cmd_ready=%b required 1", name, bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 0;
        bus.cmd_rs1 = 2'($urandom); bus.cmd_rs2 = 2'($urandom); bus.cmd_imm = 8'($urandom);
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat != (legal ? 2 : 1)) begin
            errors++; $display("FAIL %s latency: %0d cycles required %0d", name, lat, legal ? 2 : 1);
        end
        if (legal) begin
            m_flags = exp_f; m_last_op = op; m_last_a = a; m_last_b = b;
            if (wb) m_rf[rd] = exp_d;
        end
        obs_d = bus.rsp_data; obs_f = bus.rsp_flags;
        vectors++;
        if ({bus.rsp_data, bus.rsp_flags, bus.rsp_err} !== {exp_d, exp_f, !legal}) begin
            errors++;
            $display("FAIL %s response: data=%02h flags=%b err=%b required data=%02h flags=%b err=%b",
                     name, bus.rsp_data, bus.rsp_flags, bus.rsp_err, exp_d, exp_f, !legal);
        end
        vectors++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {m_last_a, m_last_b, m_last_op}) begin
            errors++;
            $display("FAIL %s alu_inputs: a=%02h b=%02h op=%h required a=%02h b=%02h op=%h",
                     name, bus.alu_a, bus.alu_b, bus.alu_op, m_last_a, m_last_b, m_last_op);
        end
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.ld_valid = 1; bus.ld_addr = 2'($urandom); bus.ld_data = 8'($urandom);
                bus.cmd_valid = 1;
            end
            @(negedge clk);
            vectors++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_flags, bus.rsp_err} !==
                {1'b1, 1'b0, exp_d, exp_f, !legal}) begin
                errors++;
                $display("FAIL %s hold: valid=%b ready=%b data=%02h flags=%b required valid=1 ready=0 data=%02h flags=%b",
                         name, bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_flags, exp_d, exp_f);
            end
        end
        bus.ld_valid = 0; bus.cmd_valid = 0;
        bus.rsp_ready = 1;
        @(negedge clk);
        bus.rsp_ready = 0;
        #1;
        vectors++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s release: rsp_valid=%b cmd_ready=%b required 0 1", name, bus.rsp_valid, bus.cmd_ready);
        end
        $display("cmd %s op=%h a=%02h b=%02h -> data=%02h flags=%b err=%b", name, op, a, b, obs_d, obs_f, !legal);
    endtask

    task automatic check_reg(input logic [1:0] r);
        logic [7:0] d; logic [3:0] f;
        do_cmd(OP_ADD, 2'd0, r, 2'd0, 1'b1, 8'h00, 1'b0, 0, 1'b0, "readback", d, f);
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_flags, bus.rsp_err,
             bus.alu_a, bus.alu_b, bus.alu_op} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%02h flags=%b err=%b a=%02h b=%02h op=%h required all 0",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_flags, bus.rsp_err,
                     bus.alu_a, bus.alu_b, bus.alu_op);
        end
        rst = 0;
        model_reset();
        @(negedge clk);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: cmd_ready=%b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] d; logic [3:0] f;
        do_load(2'd0, 8'h7F);
        do_load(2'd1, 8'h01);
        do_cmd(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 0, 1'b0, "add_ovf", d, f);
        vectors++;
        if ({d, f} !== {8'h80, 4'b0101}) begin
            errors++; $display("FAIL add_ovf_const: data=%02h flags=%b required 80 0101", d, f);
        end
        do_cmd(4'b1110, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 3, 1'b1, "illegal", d, f);
        vectors++;
        if ({d, f} !== {8'h00, 4'b0101}) begin
            errors++; $display("FAIL illegal_const: data=%02h flags=%b required 00 0101", d, f);
        end
        check_reg(2'd2);
        check_reg(2'd0);
        do_load(2'd0, 8'h00);
        do_cmd(OP_SUB, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 1, 1'b0, "sub_borrow", d, f);
        vectors++;
        if ({d, f} !== {8'hFF, 4'b0110}) begin
            errors++; $display("FAIL sub_borrow_const: data=%02h flags=%b required ff 0110", d, f);
        end
        check_reg(2'd0);
        do_load(2'd3, 8'h80);
        do_cmd(OP_SLT, 2'd3, 2'd3, 2'd0, 1'b1, 8'h01, 1'b1, 0, 1'b0, "slt_neg", d, f);
        vectors++;
        if ({d, f} !== {8'h01, 4'b0000}) begin
            errors++; $display("FAIL slt_neg_const: data=%02h flags=%b required 01 0000", d, f);
        end
        check_reg(2'd3);
    endtask

    task automatic test_load_collision_and_reset();
        logic [7:0] d; logic [3:0] f;
        bus.ld_valid = 1; bus.ld_addr = 2'd1; bus.ld_data = 8'h5A;
        bus.cmd_valid = 1; bus.cmd_op = OP_ADD; bus.cmd_rd = 2'd1; bus.cmd_rs1 = 2'd1;
        bus.cmd_imm_en = 1; bus.cmd_imm = 8'h03; bus.cmd_wb = 1;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL collide_ready: cmd_ready=%b required 0", bus.cmd_ready);
        end
        @(negedge clk);
        bus.ld_valid = 0;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL collide_next_ready: cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 0;
        vectors++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {8'h5A, 8'h03, OP_ADD}) begin
            errors++;
            $display("FAIL collide_operands: a=%02h b=%02h op=%h required 5a 03 0", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        #1 rst = 1;
        #1;
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_flags, bus.rsp_err,
             bus.alu_a, bus.alu_b, bus.alu_op} !== 35'd0) begin
            errors++;
            $display("FAIL reset_exec: ready=%b valid=%b data=%02h a=%02h b=%02h op=%h required all 0",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.alu_a, bus.alu_b, bus.alu_op);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
        check_reg(2'd1);
        do_cmd(OP_PASSB, 2'd0, 2'd0, 2'd0, 1'b1, 8'hA5, 1'b1, 0, 1'b0, "post_reset", d, f);
    endtask

    task automatic test_random();
        logic [7:0] d; logic [3:0] f;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 3) do_load(2'($urandom), 8'($urandom));
            do_cmd(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                   8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "random", d, f);
        end
        for (int r = 0; r < 4; r++) check_reg(2'(r));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_load_collision_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-side controller for the 8-bit combinational ALU. It drives the ALU's A, B and opcode inputs and consumes its Result and Z/S/C/V outputs.
- It owns a small operand register file and a sticky flag register.
- It accepts commands over a valid/ready handshake, sequences one ALU operation per command, writes the result back, and returns the result and flags over a response handshake.
- It sits between an instruction source (test sequencer or future decoder) and the ALU instance.

Parameters:
- DW, 8, datapath width; fixed to the ALU width; other values unsupported.
- NREG, 4, number of operand registers.
- RW, 2, register address width; must equal clog2(NREG).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ld_valid  in  1  direct register load request.
- ld_addr  in  RW  load target register.
- ld_data  in  DW  load value.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  4  ALU opcode.
- cmd_rd  in  RW  destination register.
- cmd_rs1  in  RW  source register for A.
- cmd_rs2  in  RW  source register for B.
- cmd_imm_en  in  1  B taken from cmd_imm instead of rs2.
- cmd_imm  in  DW  immediate operand.
- cmd_wb  in  1  write result to rd (0 = flags/compare only).
- alu_a  out  DW  registered operand A to ALU.
- alu_b  out  DW  registered operand B to ALU.
- alu_op  out  4  registered opcode to ALU.
- alu_result  in  DW  ALU Result.
- alu_z, alu_s, alu_c, alu_v  in  1 each  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_data  out  DW  result of the operation.
- rsp_flags  out  4  {Z,S,C,V} after the operation.
- rsp_err  out  1  illegal opcode rejected.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all registers 0; flags 0.
  - alu_a=alu_b=0, alu_op=4'b0000.
  - rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, cmd_ready=0 while rst high.
- Reset mid-operation abandons the command: no writeback, no flag update, no response.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready = ~ld_valid.
    - ld_valid has priority: it writes rf[ld_addr]=ld_data at the edge and blocks command acceptance that cycle.
    - ld_valid is ignored outside IDLE.
  - Accept (IDLE, cmd_valid & cmd_ready) with legal op (0000..1101):
    - Register alu_a=rf[rs1].
    - Register alu_b = cmd_imm_en ? cmd_imm : rf[rs2].
    - Register alu_op=cmd_op; latch rd and wb; go to EXEC.
    - Operands are read at acceptance, so rd==rs1/rs2 is safe.
  - Accept with illegal op (1110, 1111):
    - ALU outputs are not touched.
    - rsp_err=1, rsp_data=0, rsp_flags=current flags (unchanged); go to RESP.
  - EXEC (exactly one cycle; ALU settles combinationally), at the edge:
    - rsp_data=alu_result; rsp_flags={alu_z,alu_s,alu_c,alu_v}; flag register updated.
    - If wb, rf[rd]=alu_result.
    - rsp_err=0; go to RESP.
  - RESP: rsp_valid=1, held stable until rsp_ready is sampled high; then go to IDLE.
    - rsp_valid deasserts the cycle after the handshake.
    - cmd_ready=0 in EXEC and RESP.
- Latency: rsp_valid rises 2 cycles after a legal accept and 1 cycle after an illegal accept. With rsp_ready held high, throughput is 1 command per 3 cycles.
- alu_a, alu_b and alu_op hold their last values outside EXEC; no glitch-free guarantee is required on them.
- Flags are replaced wholesale by every legal op, including logic and rotate ops where the ALU reports C=V=0.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_ROR (0000..1101) and OP_ILLEGAL_MIN=4'b1110.
  - flag bit indices FLG_Z=3, FLG_S=2, FLG_C=1, FLG_V=0.
  - FSM state encoding.
- One sub-module: alu_regfile, with NREG x DW storage, 2 asynchronous read ports and 1 synchronous write port, and async reset to 0.
- The write-port mux (load vs writeback) stays in alu_issue_ctrl.

Test Plan:
- Load r0=0x7F, r1=0x01; ADD rd=2,rs1=0,rs2=1,wb=1 -> rsp_data=0x80, rsp_flags=4'b0101, r2=0x80, rsp_valid exactly 2 cycles after accept.
- r0=0x00; SUB rs1=0, imm_en=1, imm=0x01 -> rsp_data=0xFF, rsp_flags=4'b0110; with wb=0, r0 stays 0x00.
- Load r3=0x80; SLT rs1=3, imm=0x01, rd=3 -> rsp_data=0x01, rsp_flags=4'b0000, r3=0x01.
- cmd_op=4'b1110 after the ADD test -> rsp_err=1, rsp_data=0x00, rsp_flags=4'b0101, no register change, alu_op unchanged.
- Hold rsp_ready low for 3 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready=0 throughout, ld_valid has no effect; release -> IDLE next cycle.
- In IDLE, assert ld_valid and cmd_valid together -> load applied, cmd_ready=0; command accepted next cycle. Then assert rst during EXEC -> all outputs 0 immediately and rd not written.
